// File: rtl/cmd_exec.sv
// cmd_exec: command responder. Queues rdy/cmd/opd commands in a small FIFO and executes
// them one at a time, reporting each with a one-cycle done pulse, echoed code and result.

module cmd_exec #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy_i,
  input  logic [2:0]   cmd_i,
  input  logic [W-1:0] opd1_i,
  input  logic [W-1:0] opd2_i,
  output logic         done_o,
  output logic [2:0]   done_cmd_o,
  output logic [W-1:0] result_o,
  output logic         dz_o,
  output logic         ovf_o,
  output logic         halted_o,
  output logic [AW:0]  fifo_lvl_o
);

  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] C_RST  = 3'd0;
  localparam logic [2:0] C_INIT = 3'd1;
  localparam logic [2:0] C_ADD  = 3'd2;
  localparam logic [2:0] C_SUB  = 3'd3;
  localparam logic [2:0] C_MULT = 3'd4;
  localparam logic [2:0] C_DIV  = 3'd5;
  localparam logic [2:0] C_REM  = 3'd6;
  localparam logic [2:0] C_HLT  = 3'd7;

  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cmd_mem_q [DEPTH];
  logic [W-1:0]  opa_mem_q [DEPTH];
  logic [W-1:0]  opb_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
  logic [2:0]    op_cmd_q, op_cmd_d;
  logic [W-1:0]  opa_q, opa_d, opb_q, opb_d, rem_q, rem_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          done_q, done_d;
  logic [2:0]    done_cmd_q, done_cmd_d;
  logic [W-1:0]  result_q, result_d;
  logic          dz_q, dz_d, ovf_q, ovf_d, halted_q, halted_d, rst_pend_q, rst_pend_d;

  logic          wr_req_s, rst_cmd_s, full_s, pop_s, wr_en_s, drop_s;
  logic [2:0]    head_cmd_s;
  logic [W-1:0]  head_a_s, head_b_s;
  logic [W:0]    shift_s, trial_s;

  assign rst_cmd_s  = rdy_i && (cmd_i == C_RST);
  assign wr_req_s   = rdy_i && (cmd_i != C_RST);
  assign full_s     = (fifo_cnt_q == FULL_LVL);
  assign pop_s      = !rst_cmd_s && (state_q == S_IDLE) && (fifo_cnt_q != '0);
  assign wr_en_s    = wr_req_s && (!full_s || pop_s);
  assign drop_s     = wr_req_s && full_s && !pop_s;
  assign head_cmd_s = cmd_mem_q[rd_ptr_q];
  assign head_a_s   = opa_mem_q[rd_ptr_q];
  assign head_b_s   = opb_mem_q[rd_ptr_q];

  // Restoring divider step: opa_q shifts the dividend out and the quotient in.
  assign shift_s = {rem_q, opa_q[W-1]};
  assign trial_s = shift_s - {1'b0, opb_q};

  // FIFO pointer and occupancy next-state; an RST command flushes the queue.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (rst_cmd_s) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      if (wr_en_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else         wr_ptr_d = wr_ptr_q;
      if (pop_s)   rd_ptr_d = rd_ptr_q + AW'(1);
      else         rd_ptr_d = rd_ptr_q;
      case ({wr_en_s, pop_s})
        2'b10:   fifo_cnt_d = fifo_cnt_q + (AW + 1)'(1);
        2'b01:   fifo_cnt_d = fifo_cnt_q - (AW + 1)'(1);
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  // Engine FSM next-state, operand/divider datapath and completion reporting.
  always_comb begin
    state_d    = state_q;
    op_cmd_d   = op_cmd_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rem_d      = rem_q;
    div_cnt_d  = div_cnt_q;
    done_d     = 1'b0;
    done_cmd_d = done_cmd_q;
    result_d   = result_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    halted_d   = halted_q;
    rst_pend_d = 1'b0;
    if (rst_cmd_s) begin
      state_d    = S_IDLE;
      halted_d   = 1'b0;
      rst_pend_d = 1'b1;
    end else begin
      if (rst_pend_q) begin
        done_d     = 1'b1;
        done_cmd_d = C_RST;
        result_d   = '0;
        dz_d       = 1'b0;
      end else begin
        done_d = 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            op_cmd_d  = head_cmd_s;
            opa_d     = head_a_s;
            opb_d     = head_b_s;
            rem_d     = '0;
            div_cnt_d = '0;
            if (((head_cmd_s == C_DIV) || (head_cmd_s == C_REM)) && (head_b_s != '0)) begin
              state_d = S_DIV;
            end else begin
              state_d = S_EXEC;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_EXEC: begin
          done_d     = 1'b1;
          done_cmd_d = op_cmd_q;
          dz_d       = 1'b0;
          state_d    = S_IDLE;
          case (op_cmd_q)
            C_INIT: begin
              result_d = '0;
              ovf_d    = 1'b0;
            end
            C_ADD:  result_d = opa_q + opb_q;
            C_SUB:  result_d = opa_q - opb_q;
            C_MULT: result_d = opa_q * opb_q;
            // Only zero-divisor DIV/REM reach EXEC.
            C_DIV: begin
              result_d = '1;
              dz_d     = 1'b1;
            end
            C_REM: begin
              result_d = opa_q;
              dz_d     = 1'b1;
            end
            C_HLT: begin
              result_d = '0;
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
            default: result_d = '0;
          endcase
        end
        S_DIV: begin
          if (div_cnt_q == DIV_LAST) begin
            done_d     = 1'b1;
            done_cmd_d = op_cmd_q;
            dz_d       = 1'b0;
            result_d   = (op_cmd_q == C_DIV) ? opa_q : rem_q;
            state_d    = S_IDLE;
          end else begin
            div_cnt_d = div_cnt_q + CW'(1);
            if (!trial_s[W]) begin
              rem_d = trial_s[W-1:0];
              opa_d = {opa_q[W-2:0], 1'b1};
            end else begin
              rem_d = shift_s[W-1:0];
              opa_d = {opa_q[W-2:0], 1'b0};
            end
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
    if (drop_s) ovf_d = 1'b1;
    else        ovf_d = ovf_d;
  end

  // State, control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      op_cmd_q   <= 3'd0;
      opa_q      <= '0;
      opb_q      <= '0;
      rem_q      <= '0;
      div_cnt_q  <= '0;
      done_q     <= 1'b0;
      done_cmd_q <= 3'd0;
      result_q   <= '0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      halted_q   <= 1'b0;
      rst_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      op_cmd_q   <= op_cmd_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      rem_q      <= rem_d;
      div_cnt_q  <= div_cnt_d;
      done_q     <= done_d;
      done_cmd_q <= done_cmd_d;
      result_q   <= result_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
      halted_q   <= halted_d;
      rst_pend_q <= rst_pend_d;
    end
  end

  // FIFO storage; entries are qualified by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      cmd_mem_q[wr_ptr_q] <= cmd_i;
      opa_mem_q[wr_ptr_q] <= opd1_i;
      opb_mem_q[wr_ptr_q] <= opd2_i;
    end
  end

  assign done_o     = done_q;
  assign done_cmd_o = done_cmd_q;
  assign result_o   = result_q;
  assign dz_o       = dz_q;
  assign ovf_o      = ovf_q;
  assign halted_o   = halted_q;
  assign fifo_lvl_o = fifo_cnt_q;

endmodule

// File: tb/tb_cmd_exec.sv
// Self-checking bench for cmd_exec: directed command sequence, expected completions
// queued on issue and compared when done_o fires.

module tb_cmd_exec;

  localparam int W     = 64;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  localparam logic [2:0] C_RST  = 3'd0;
  localparam logic [2:0] C_INIT = 3'd1;
  localparam logic [2:0] C_ADD  = 3'd2;
  localparam logic [2:0] C_SUB  = 3'd3;
  localparam logic [2:0] C_MULT = 3'd4;
  localparam logic [2:0] C_DIV  = 3'd5;
  localparam logic [2:0] C_REM  = 3'd6;
  localparam logic [2:0] C_HLT  = 3'd7;

  logic         clk;
  logic         rst_n;
  logic         rdy_i;
  logic [2:0]   cmd_i;
  logic [W-1:0] opd1_i;
  logic [W-1:0] opd2_i;
  logic         done_o;
  logic [2:0]   done_cmd_o;
  logic [W-1:0] result_o;
  logic         dz_o;
  logic         ovf_o;
  logic         halted_o;
  logic [AW:0]  fifo_lvl_o;

  int tests_run = 0;
  int failed    = 0;

  typedef struct packed {
    logic [2:0]   cmd;
    logic [W-1:0] res;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  cmd_exec #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy_i     (rdy_i),
    .cmd_i     (cmd_i),
    .opd1_i    (opd1_i),
    .opd2_i    (opd2_i),
    .done_o    (done_o),
    .done_cmd_o(done_cmd_o),
    .result_o  (result_o),
    .dz_o      (dz_o),
    .ovf_o     (ovf_o),
    .halted_o  (halted_o),
    .fifo_lvl_o(fifo_lvl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.cmd = c;
    e.dz  = 1'b0;
    case (c)
      C_ADD:  e.res = a + b;
      C_SUB:  e.res = a - b;
      C_MULT: e.res = a * b;
      C_DIV: begin
        e.res = (b == '0) ? '1 : a / b;
        e.dz  = (b == '0);
      end
      C_REM: begin
        e.res = (b == '0) ? a : a % b;
        e.dz  = (b == '0);
      end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  task automatic push_exp(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    sb.push_back(model(c, a, b));
  endtask

  task automatic drive(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    rdy_i  = 1'b1;
    cmd_i  = c;
    opd1_i = a;
    opd2_i = b;
  endtask

  task automatic release_rdy();
    @(negedge clk);
    rdy_i = 1'b0;
    cmd_i = C_RST;
  endtask

  task automatic send1(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    drive(c, a, b);
    release_rdy();
  endtask

  // Counts negedges until done_o is seen; an expired budget is a failure.
  task automatic wait_done(input int limit, output int n);
    logic seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      seen = done_o;
    end
    check("done_timeout", 64'(seen), 64'd1);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      tests_run++;
      assert (sb.size() > 0) else begin
        failed++;
        $error("FAIL sb_unexpected_done: observed cmd %0d result %h, expected no done", done_cmd_o, result_o);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("sb_cmd", 64'(done_cmd_o), 64'(mon_e.cmd));
        check("sb_result", result_o, mon_e.res);
        check("sb_dz", 64'(dz_o), 64'(mon_e.dz));
      end
    end
  end

  initial begin
    int lat;
    rst_n  = 1'b0;
    rdy_i  = 1'b0;
    cmd_i  = C_RST;
    opd1_i = '0;
    opd2_i = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_lvl", 64'(fifo_lvl_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    check("rst_halted", 64'(halted_o), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: ADD into an idle block
    push_exp(C_ADD, 64'd5, 64'd3);
    send1(C_ADD, 64'd5, 64'd3);
    wait_done(10, lat);
    check("add_latency", 64'(lat), 64'd2);
    check("add_cmd", 64'(done_cmd_o), 64'd2);
    check("add_result", result_o, 64'd8);
    @(negedge clk);
    check("done_one_cycle", 64'(done_o), 64'd0);
    check("result_holds", result_o, 64'd8);

    // 2: SUB wrap and MULT truncation, back to back
    push_exp(C_SUB, 64'd0, 64'd1);
    push_exp(C_MULT, 64'd1 << 40, 64'd1 << 30);
    drive(C_SUB, 64'd0, 64'd1);
    drive(C_MULT, 64'd1 << 40, 64'd1 << 30);
    release_rdy();
    wait_done(10, lat);
    check("sub_result", result_o, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(10, lat);
    check("mult_result", result_o, 64'd0);

    // 3: DIV / REM / divide by zero
    push_exp(C_DIV, 64'd100, 64'd7);
    send1(C_DIV, 64'd100, 64'd7);
    wait_done(200, lat);
    check("div_latency", 64'(lat), 64'(W + 2));
    check("div_result", result_o, 64'd14);
    push_exp(C_REM, 64'd100, 64'd7);
    send1(C_REM, 64'd100, 64'd7);
    wait_done(200, lat);
    check("rem_result", result_o, 64'd2);
    push_exp(C_DIV, 64'd9, 64'd0);
    send1(C_DIV, 64'd9, 64'd0);
    wait_done(10, lat);
    check("dz_latency", 64'(lat), 64'd2);
    check("dz_flag", 64'(dz_o), 64'd1);
    check("dz_result", result_o, 64'hFFFF_FFFF_FFFF_FFFF);

    // 4: overflow while the divider is busy; the fifth ADD is dropped
    push_exp(C_DIV, 64'd1000, 64'd10);
    drive(C_DIV, 64'd1000, 64'd10);
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) push_exp(C_ADD, 64'(i), 64'(10 * i));
      drive(C_ADD, 64'(i), 64'(10 * i));
    end
    release_rdy();
    check("ovf_lvl_full", 64'(fifo_lvl_o), 64'(DEPTH));
    check("ovf_set", 64'(ovf_o), 64'd1);
    for (int i = 0; i < 5; i++) wait_done(100, lat);
    repeat (5) @(negedge clk);
    check("ovf_drained", 64'(sb.size()), 64'd0);
    check("ovf_sticky", 64'(ovf_o), 64'd1);
    push_exp(C_INIT, 64'd0, 64'd0);
    send1(C_INIT, 64'd0, 64'd0);
    wait_done(10, lat);
    check("init_clears_ovf", 64'(ovf_o), 64'd0);

    // 5: HLT parks the engine; RST releases it and flushes the queue
    push_exp(C_HLT, 64'd0, 64'd0);
    drive(C_HLT, 64'd0, 64'd0);
    drive(C_ADD, 64'd11, 64'd22);
    release_rdy();
    repeat (10) @(negedge clk);
    check("halted", 64'(halted_o), 64'd1);
    check("halt_lvl", 64'(fifo_lvl_o), 64'd1);
    push_exp(C_RST, 64'd0, 64'd0);
    send1(C_RST, 64'd0, 64'd0);
    check("rst_cmd_lvl", 64'(fifo_lvl_o), 64'd0);
    check("rst_cmd_unhalt", 64'(halted_o), 64'd0);
    @(negedge clk);
    check("rst_cmd_done", 64'(done_o), 64'd1);
    check("rst_cmd_code", 64'(done_cmd_o), 64'd0);

    // 6: asynchronous reset in the middle of a divide
    push_exp(C_ADD, 64'd7, 64'd9);
    send1(C_ADD, 64'd7, 64'd9);
    wait_done(10, lat);
    drive(C_DIV, 64'd12345, 64'd3);
    drive(C_ADD, 64'd1, 64'd1);
    release_rdy();
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_done", 64'(done_o), 64'd0);
    check("arst_cmd", 64'(done_cmd_o), 64'd0);
    check("arst_result", result_o, 64'd0);
    check("arst_lvl", 64'(fifo_lvl_o), 64'd0);
    check("arst_dz", 64'(dz_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(C_ADD, 64'd20, 64'd22);
    send1(C_ADD, 64'd20, 64'd22);
    wait_done(10, lat);
    check("post_arst_latency", 64'(lat), 64'd2);
    check("post_arst_result", result_o, 64'd42);

    repeat (5) @(negedge clk);
    check("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
